// File: rtl/fabric_pkg.sv
// Shared types for the fabric sequencer: state encoding, program-entry layout
// and the row-select width helper.
package fabric_pkg;

   localparam int unsigned FAB_ROWS             = 2;
   localparam int unsigned FAB_INSTR_DATA_WIDTH = 32;
   localparam int unsigned FAB_INSTR_ADDR_WIDTH = 6;
   localparam int unsigned FAB_INSTR_HOPS_WIDTH = 4;
   localparam int unsigned FAB_PROG_ADDR_WIDTH  = 10;
   localparam int unsigned FAB_CNT_WIDTH        = 32;

   // Row-select field width, never narrower than one bit.
   function automatic int unsigned row_w(input int unsigned rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

   localparam int unsigned ROW_W = row_w(FAB_ROWS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_CALL,
      ST_SETTLE,
      ST_WAIT_RET,
      ST_DONE
   } seq_state_e;

   typedef struct packed {
      logic                            last;
      logic [ROW_W-1:0]                row;
      logic [FAB_INSTR_HOPS_WIDTH-1:0] hops;
      logic [FAB_INSTR_DATA_WIDTH-1:0] instr;
   } prog_entry_t;

endpackage

// File: rtl/fabric_seq_ctrl_if.sv
// Host, program-memory and fabric-side signals of the fabric sequencer.
interface fabric_seq_ctrl_if #(
   parameter int unsigned ROWS             = 2,
   parameter int unsigned INSTR_DATA_WIDTH = 32,
   parameter int unsigned INSTR_ADDR_WIDTH = 6,
   parameter int unsigned INSTR_HOPS_WIDTH = 4,
   parameter int unsigned PROG_ADDR_WIDTH  = 10,
   parameter int unsigned CNT_WIDTH        = 32
);
   localparam int unsigned ENTRY_W =
      1 + fabric_pkg::row_w(ROWS) + INSTR_HOPS_WIDTH + INSTR_DATA_WIDTH;

   logic                                     start;
   logic [PROG_ADDR_WIDTH-1:0]               prog_base;
   logic                                     prog_rd_en;
   logic [PROG_ADDR_WIDTH-1:0]               prog_addr;
   logic [ENTRY_W-1:0]                       prog_rdata;
   logic [ROWS-1:0][INSTR_DATA_WIDTH-1:0]    instr_data_out;
   logic [ROWS-1:0][INSTR_ADDR_WIDTH-1:0]    instr_addr_out;
   logic [ROWS-1:0][INSTR_HOPS_WIDTH-1:0]    instr_hops_out;
   logic [ROWS-1:0]                          instr_en_out;
   logic [ROWS-1:0]                          call;
   logic [ROWS-1:0]                          ret;
   logic                                     busy;
   logic                                     done;
   logic [CNT_WIDTH-1:0]                     cycle_count;
   logic                                     err_row;
   logic                                     err_timeout;

   modport master (
      input  start, prog_base, prog_rdata, ret,
      output prog_rd_en, prog_addr, instr_data_out, instr_addr_out,
             instr_hops_out, instr_en_out, call, busy, done, cycle_count,
             err_row, err_timeout
   );

   modport slave (
      output start, prog_base, prog_rdata, ret,
      input  prog_rd_en, prog_addr, instr_data_out, instr_addr_out,
             instr_hops_out, instr_en_out, call, busy, done, cycle_count,
             err_row, err_timeout
   );

endinterface

// File: rtl/fabric_seq_cell_index.sv
// Per-cell instruction address: restarts at 0 whenever the {row,hops} key
// changes (or on the first entry of a run) and otherwise counts up, wrapping.
module fabric_seq_cell_index #(
   parameter int unsigned KEY_W = 5,
   parameter int unsigned IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             valid,
   input  logic [KEY_W-1:0] key,
   output logic [IDX_W-1:0] idx_c
);

   logic             have_prev;
   logic [KEY_W-1:0] prev_key;
   logic [IDX_W-1:0] prev_idx;

   always_comb begin
      idx_c = '0;
      if (have_prev && (key == prev_key)) begin
         idx_c = prev_idx + IDX_W'(1);
      end
   end

   // Only accepted entries update history, so dropped entries leave it intact.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         have_prev <= 1'b0;
         prev_key  <= '0;
         prev_idx  <= '0;
      end else if (clear) begin
         have_prev <= 1'b0;
      end else if (valid) begin
         have_prev <= 1'b1;
         prev_key  <= key;
         prev_idx  <= idx_c;
      end
   end

endmodule

// File: rtl/fabric_seq_ctrl.sv
// Program-memory driven load/call/wait sequencer for the fabric.
// Optional WAIT_RET watchdog is enabled by defining FABRIC_SEQ_TIMEOUT_EN.
module fabric_seq_ctrl
   import fabric_pkg::*;
#(
   parameter int unsigned ROWS             = FAB_ROWS,
   parameter int unsigned INSTR_DATA_WIDTH = FAB_INSTR_DATA_WIDTH,
   parameter int unsigned INSTR_ADDR_WIDTH = FAB_INSTR_ADDR_WIDTH,
   parameter int unsigned INSTR_HOPS_WIDTH = FAB_INSTR_HOPS_WIDTH,
   parameter int unsigned PROG_ADDR_WIDTH  = FAB_PROG_ADDR_WIDTH,
   parameter int unsigned CNT_WIDTH        = FAB_CNT_WIDTH,
   parameter int unsigned SETTLE_CYCLES    = 16
`ifdef FABRIC_SEQ_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES   = 1000000
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   fabric_seq_ctrl_if.master  bus
);

   localparam int unsigned RW = row_w(ROWS);
   localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
`ifdef FABRIC_SEQ_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
`endif

   seq_state_e                  state;
   logic [PROG_ADDR_WIDTH-1:0]  ptr;
   logic                        rvalid;
   logic [SW-1:0]               settle_cnt;
`ifdef FABRIC_SEQ_TIMEOUT_EN
   logic [TW-1:0]               wait_cnt;
`endif

   logic                        e_last;
   logic [RW-1:0]               e_row;
   logic [INSTR_HOPS_WIDTH-1:0] e_hops;
   logic [INSTR_DATA_WIDTH-1:0] e_instr;
   logic                        row_ok_c;
   logic                        accept_c;
   logic                        entry_ok_c;
   logic [INSTR_ADDR_WIDTH-1:0] idx_c;

   assign {e_last, e_row, e_hops, e_instr} = bus.prog_rdata;
   assign row_ok_c   = (32'(e_row) < ROWS);
   assign accept_c   = (state == ST_IDLE) && bus.start;
   assign entry_ok_c = (state == ST_LOAD) && rvalid && row_ok_c;

   fabric_seq_cell_index #(
      .KEY_W (RW + INSTR_HOPS_WIDTH),
      .IDX_W (INSTR_ADDR_WIDTH)
   ) u_cell_index (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (accept_c),
      .valid (entry_ok_c),
      .key   ({e_row, e_hops}),
      .idx_c (idx_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= ST_IDLE;
         ptr                <= '0;
         rvalid             <= 1'b0;
         settle_cnt         <= '0;
`ifdef FABRIC_SEQ_TIMEOUT_EN
         wait_cnt           <= '0;
`endif
         bus.prog_rd_en     <= 1'b0;
         bus.prog_addr      <= '0;
         bus.instr_data_out <= '0;
         bus.instr_addr_out <= '0;
         bus.instr_hops_out <= '0;
         bus.instr_en_out   <= '0;
         bus.call           <= '0;
         bus.busy           <= 1'b0;
         bus.done           <= 1'b0;
         bus.cycle_count    <= '0;
         bus.err_row        <= 1'b0;
         bus.err_timeout    <= 1'b0;
      end else begin
         bus.prog_rd_en     <= 1'b0;
         bus.instr_data_out <= '0;
         bus.instr_addr_out <= '0;
         bus.instr_hops_out <= '0;
         bus.instr_en_out   <= '0;
         bus.call           <= '0;
         bus.done           <= 1'b0;
         rvalid             <= bus.prog_rd_en;

         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  ptr             <= bus.prog_base;
                  bus.err_row     <= 1'b0;
                  bus.err_timeout <= 1'b0;
                  bus.cycle_count <= '0;
                  bus.busy        <= 1'b1;
                  state           <= ST_FETCH;
               end
            end

            ST_FETCH: begin
               bus.prog_rd_en <= 1'b1;
               bus.prog_addr  <= ptr;
               ptr            <= ptr + PROG_ADDR_WIDTH'(1);
               state          <= ST_LOAD;
            end

            // Reads stream ahead one entry; the read issued alongside the
            // last entry returns during CALL and is discarded.
            ST_LOAD: begin
               if (rvalid && e_last) begin
                  state <= ST_CALL;
               end else begin
                  bus.prog_rd_en <= 1'b1;
                  bus.prog_addr  <= ptr;
                  ptr            <= ptr + PROG_ADDR_WIDTH'(1);
               end
               if (rvalid) begin
                  if (row_ok_c) begin
                     for (int r = 0; r < ROWS; r++) begin
                        if (int'(e_row) == r) begin
                           bus.instr_en_out[r]   <= 1'b1;
                           bus.instr_data_out[r] <= e_instr;
                           bus.instr_addr_out[r] <= idx_c;
                           bus.instr_hops_out[r] <= e_hops;
                        end
                     end
                  end else begin
                     bus.err_row <= 1'b1;
                  end
               end
            end

            ST_CALL: begin
               bus.call        <= '1;
               bus.cycle_count <= '0;
               settle_cnt      <= '0;
               state           <= ST_SETTLE;
            end

            // First SETTLE edge closes the call cycle itself and is not counted.
            ST_SETTLE: begin
               if (settle_cnt != '0) begin
                  bus.cycle_count <= (&bus.cycle_count) ? bus.cycle_count
                                     : bus.cycle_count + CNT_WIDTH'(1);
               end
               if (settle_cnt == SW'(SETTLE_CYCLES)) begin
`ifdef FABRIC_SEQ_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
                  state    <= ST_WAIT_RET;
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end

            ST_WAIT_RET: begin
               bus.cycle_count <= (&bus.cycle_count) ? bus.cycle_count
                                  : bus.cycle_count + CNT_WIDTH'(1);
               if (&bus.ret) begin
                  bus.done <= 1'b1;
                  state    <= ST_DONE;
               end
`ifdef FABRIC_SEQ_TIMEOUT_EN
               else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  bus.err_timeout <= 1'b1;
                  bus.done        <= 1'b1;
                  state           <= ST_DONE;
               end else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
`endif
            end

            ST_DONE: begin
               bus.busy <= 1'b0;
               state    <= ST_IDLE;
            end

            default: begin
               bus.busy <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
